// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Shared types and constants for the traffic light monitor:
//               monitor phase encoding, fault-cause codes, the seven-segment
//               lookup table (bit order a..g, MSB = a) and countdown defaults.
// Revision    : 1.0  initial release
// ============================================================================
package traffic_pkg;

    typedef enum logic [1:0] {
        PH_SYNC  = 2'd0,
        PH_MAIN  = 2'd1,
        PH_CROSS = 2'd2,
        PH_FAULT = 2'd3
    } phase_e;

    localparam logic [2:0] c_fault_none     = 3'd0;
    localparam logic [2:0] c_fault_lamp     = 3'd1;
    localparam logic [2:0] c_fault_seg      = 3'd2;
    localparam logic [2:0] c_fault_mismatch = 3'd3;
    localparam logic [2:0] c_fault_count    = 3'd4;
    localparam logic [2:0] c_fault_phase    = 3'd5;
    localparam logic [2:0] c_fault_wdog     = 3'd6;

    localparam int c_mtimer_default = 7;
    localparam int c_ctimer_default = 5;

    // Element [d] holds the segment pattern for digit d (first listed = 7).
    localparam logic [7:0][6:0] c_seg_table = {
        7'b1110000,  // 7
        7'b1011111,  // 6
        7'b1011011,  // 5
        7'b0110011,  // 4
        7'b1111001,  // 3
        7'b1101101,  // 2
        7'b0110000,  // 1
        7'b1111110   // 0
    };

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_decode
// Description : Combinational seven-segment to digit decoder (0..7).
//               i_code  : 7-bit segment pattern, bit order a..g, active-high
//               o_digit : decoded value (0 when the pattern is illegal)
//               o_valid : 1 when i_code matches one of the eight table entries
// Revision    : 1.0  initial release
// ============================================================================
module seg7_decode
    import traffic_pkg::*;
(
    input  logic [6:0] i_code,
    output logic [2:0] o_digit,
    output logic       o_valid
);

    always_comb begin
        o_digit = 3'd0;
        o_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i_code == c_seg_table[i]) begin
                o_digit = 3'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/traffic_light_monitor.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_monitor
// Description : Observes a two-road traffic light controller on each tick and
//               checks lamp legality, display decoding/agreement, countdown
//               sequencing and phase changes; latches the first fault cause.
// Ports       : clk, reset (async, active-high), tick (count strobe),
//               MG/MR/CG/CR (lamps), displayM/displayC (7-seg, a..g),
//               fault_clear (level) -> digitM/digitC, phase, fault,
//               fault_code, cycle_count (saturating at 255).
// Options     : TICK_WATCHDOG_EN - adds a missing-tick watchdog (code 6)
//               with a window of WDOG_CYCLES clk cycles.
// Revision    : 1.0  initial release
// ============================================================================
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int MTIMER      = c_mtimer_default,
    parameter int CTIMER      = c_ctimer_default,
    parameter int WDOG_CYCLES = 100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       MG,
    input  logic       MR,
    input  logic       CG,
    input  logic       CR,
    input  logic [6:0] displayM,
    input  logic [6:0] displayC,
    input  logic       fault_clear,
    output logic [2:0] digitM,
    output logic [2:0] digitC,
    output logic [1:0] phase,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [7:0] cycle_count
);

    phase_e     r_phase;
    logic       r_fault;
    logic [2:0] r_fault_code;
    logic [2:0] r_digit_m;
    logic [2:0] r_digit_c;
    logic [7:0] r_cycle_count;

    logic [2:0] w_dec_m;
    logic [2:0] w_dec_c;
    logic       w_valid_m;
    logic       w_valid_c;
    logic       w_lamp_main;
    logic       w_lamp_cross;
    logic       w_same_set;
    logic [2:0] w_target;
    logic [2:0] w_tick_code;
    logic [2:0] w_new_code;
    logic       w_active;
    logic       w_wdog_fault;

    seg7_decode u_dec_m (
        .i_code  (displayM),
        .o_digit (w_dec_m),
        .o_valid (w_valid_m)
    );

    seg7_decode u_dec_c (
        .i_code  (displayC),
        .o_digit (w_dec_c),
        .o_valid (w_valid_c)
    );

    assign w_lamp_main  = ({MG, MR, CG, CR} == 4'b1001);
    assign w_lamp_cross = ({MG, MR, CG, CR} == 4'b0110);
    assign w_active     = (r_phase != PH_FAULT);
    assign w_same_set   = ((r_phase == PH_MAIN)  && w_lamp_main) ||
                          ((r_phase == PH_CROSS) && w_lamp_cross);
    // Value the new phase's countdown must start from on a lamp-set change.
    assign w_target     = w_lamp_cross ? 3'(CTIMER) : 3'(MTIMER);

    // Fault cause for the current tick sample; earlier branches win, which
    // gives the lowest code priority. Countdown is only checked once synced.
    always_comb begin
        w_tick_code = c_fault_none;
        if (!w_lamp_main && !w_lamp_cross) begin
            w_tick_code = c_fault_lamp;
        end else if (!w_valid_m || !w_valid_c) begin
            w_tick_code = c_fault_seg;
        end else if (displayM != displayC) begin
            w_tick_code = c_fault_mismatch;
        end else if ((r_phase == PH_MAIN) || (r_phase == PH_CROSS)) begin
            if (w_same_set) begin
                if (r_digit_m == 3'd0) begin
                    w_tick_code = c_fault_phase;
                end else if (w_dec_m != (r_digit_m - 3'd1)) begin
                    w_tick_code = c_fault_count;
                end
            end else if ((r_digit_m != 3'd0) || (w_dec_m != w_target)) begin
                w_tick_code = c_fault_phase;
            end
        end
    end

`ifdef TICK_WATCHDOG_EN
    localparam int c_wdog_w = $clog2(WDOG_CYCLES + 1);

    logic [c_wdog_w-1:0] r_wdog_cnt;

    // Held at zero while faulted so a fault_clear does not re-trip at once;
    // saturates at the window so the fault condition stays asserted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wdog_cnt <= '0;
        end else if (tick || !w_active) begin
            r_wdog_cnt <= '0;
        end else if (r_wdog_cnt != c_wdog_w'(WDOG_CYCLES)) begin
            r_wdog_cnt <= r_wdog_cnt + 1'b1;
        end
    end

    assign w_wdog_fault = w_active && !tick &&
                          (r_wdog_cnt == c_wdog_w'(WDOG_CYCLES));
`else
    // No watchdog in this build: code 6 is unreachable. The window parameter
    // is folded into a constant-zero term so it remains referenced.
    assign w_wdog_fault = 1'b0 & (WDOG_CYCLES != 0);
`endif

    always_comb begin
        w_new_code = c_fault_none;
        if (w_active && tick && (w_tick_code != c_fault_none)) begin
            w_new_code = w_tick_code;
        end else if (w_wdog_fault) begin
            w_new_code = c_fault_wdog;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase       <= PH_SYNC;
            r_fault       <= 1'b0;
            r_fault_code  <= c_fault_none;
            r_digit_m     <= 3'd0;
            r_digit_c     <= 3'd0;
            r_cycle_count <= 8'd0;
        end else begin
            if (!w_active) begin
                // Ticks are ignored here; detection is idle, so a clear
                // request can never collide with a newly detected fault.
                if (fault_clear && (w_new_code == c_fault_none)) begin
                    r_phase      <= PH_SYNC;
                    r_fault      <= 1'b0;
                    r_fault_code <= c_fault_none;
                end
            end else if (w_new_code != c_fault_none) begin
                r_phase      <= PH_FAULT;
                r_fault      <= 1'b1;
                r_fault_code <= w_new_code;
            end else if (tick) begin
                r_phase <= w_lamp_main ? PH_MAIN : PH_CROSS;
                if ((r_phase == PH_CROSS) && w_lamp_main &&
                    (r_cycle_count != 8'd255)) begin
                    r_cycle_count <= r_cycle_count + 8'd1;
                end
            end

            // Displays are tracked on every processed tick, faulting or not;
            // an illegal pattern leaves the previous digit in place.
            if (w_active && tick) begin
                if (w_valid_m) r_digit_m <= w_dec_m;
                if (w_valid_c) r_digit_c <= w_dec_c;
            end
        end
    end

    assign digitM      = r_digit_m;
    assign digitC      = r_digit_c;
    assign phase       = r_phase;
    assign fault       = r_fault;
    assign fault_code  = r_fault_code;
    assign cycle_count = r_cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_light_monitor
// Description : Directed self-checking bench for traffic_light_monitor.
//               Builds with or without TICK_WATCHDOG_EN (window set to 50).
// Revision    : 1.0  initial release
// ============================================================================
module tb_traffic_light_monitor;

    localparam logic [3:0] c_lm = 4'b1001;  // main lamp set
    localparam logic [3:0] c_lc = 4'b0110;  // cross lamp set

    logic       clk;
    logic       reset;
    logic       tick;
    logic       MG, MR, CG, CR;
    logic [6:0] displayM;
    logic [6:0] displayC;
    logic       fault_clear;
    logic [2:0] digitM;
    logic [2:0] digitC;
    logic [1:0] phase;
    logic       fault;
    logic [2:0] fault_code;
    logic [7:0] cycle_count;

    int r_checks;
    int r_failures;

    traffic_light_monitor #(
        .MTIMER      (7),
        .CTIMER      (5),
        .WDOG_CYCLES (50)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .MG          (MG),
        .MR          (MR),
        .CG          (CG),
        .CR          (CR),
        .displayM    (displayM),
        .displayC    (displayC),
        .fault_clear (fault_clear),
        .digitM      (digitM),
        .digitC      (digitC),
        .phase       (phase),
        .fault       (fault),
        .fault_code  (fault_code),
        .cycle_count (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        r_checks++;
        if (actual !== expected) begin
            r_failures++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    function automatic logic [6:0] seg(input int d);
        case (d)
            0:       return 7'b1111110;
            1:       return 7'b0110000;
            2:       return 7'b1101101;
            3:       return 7'b1111001;
            4:       return 7'b0110011;
            5:       return 7'b1011011;
            6:       return 7'b1011111;
            7:       return 7'b1110000;
            default: return 7'b0000000;
        endcase
    endfunction

    // One tick with the given lamps/displays; returns 1 ns after the edge.
    task automatic do_tick(input logic [3:0] lamps, input logic [6:0] dm,
                           input logic [6:0] dc);
        @(negedge clk);
        {MG, MR, CG, CR} = lamps;
        displayM = dm;
        displayC = dc;
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        fault_clear = 1'b1;
        @(posedge clk);
        #1;
        fault_clear = 1'b0;
    endtask

    initial begin
        r_checks = 0;
        r_failures = 0;
        reset = 1'b1;
        tick = 1'b0;
        {MG, MR, CG, CR} = 4'b0000;
        displayM = 7'd0;
        displayC = 7'd0;
        fault_clear = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_phase", phase, 0);
        check("rst_fault", fault, 0);
        check("rst_code", fault_code, 0);
        check("rst_digitM", digitM, 0);
        check("rst_cycles", cycle_count, 0);
        @(negedge clk);
        reset = 1'b0;

        // Clean cycle: main 7..0, cross 5..0, main 7.
        do_tick(c_lm, seg(7), seg(7));
        check("sync_to_main", phase, 1);
        check("main_digit7", digitM, 7);
        for (int d = 6; d >= 0; d--) do_tick(c_lm, seg(d), seg(d));
        check("main_at0", digitC, 0);
        do_tick(c_lc, seg(5), seg(5));
        check("to_cross", phase, 2);
        check("cross_digit5", digitC, 5);
        for (int d = 4; d >= 0; d--) do_tick(c_lc, seg(d), seg(d));
        check("cross_no_fault", fault, 0);
        do_tick(c_lm, seg(7), seg(7));
        check("back_main", phase, 1);
        check("cycle_one", cycle_count, 1);
        check("clean_fault", fault, 0);

        // Both greens: lamp fault, later faults do not overwrite the code.
        do_tick(4'b1010, seg(6), seg(6));
        check("lamp_fault", fault, 1);
        check("lamp_code", fault_code, 1);
        check("lamp_phase", phase, 3);
        do_tick(c_lm, 7'b0000000, seg(1));
        check("code_held", fault_code, 1);
        check("fault_digit_held", digitM, 6);
        pulse_clear();
        check("clr_phase", phase, 0);
        check("clr_fault", fault, 0);
        check("clr_code", fault_code, 0);
        check("clr_keeps_cycles", cycle_count, 1);

        // Countdown 4 then 2.
        do_tick(c_lm, seg(4), seg(4));
        check("enter_main4", phase, 1);
        do_tick(c_lm, seg(2), seg(2));
        check("count_code", fault_code, 4);
        check("count_digit", digitM, 2);
        pulse_clear();
        check("clr2_phase", phase, 0);
        check("clr2_fault", fault, 0);

        // Lamp set change while the digit is 3.
        do_tick(c_lm, seg(3), seg(3));
        do_tick(c_lc, seg(3), seg(3));
        check("early_change", fault_code, 5);
        pulse_clear();

        // Illegal segment together with illegal lamps: code 1 wins.
        do_tick(4'b1111, 7'b0000000, seg(6));
        check("prio_code", fault_code, 1);
        check("illegal_holds_M", digitM, 3);
        check("legal_updates_C", digitC, 6);
        pulse_clear();

        // Illegal segment alone.
        do_tick(c_lm, 7'b0000000, 7'b0000000);
        check("seg_code", fault_code, 2);
        pulse_clear();

        // Displays disagree.
        do_tick(c_lm, seg(4), seg(5));
        check("mismatch_code", fault_code, 3);
        pulse_clear();

        // Same phase after reaching 0.
        do_tick(c_lm, seg(0), seg(0));
        do_tick(c_lm, seg(0), seg(0));
        check("zero_repeat", fault_code, 5);
        pulse_clear();

        // fault_clear outside FAULT has no effect.
        do_tick(c_lm, seg(7), seg(7));
        pulse_clear();
        check("clear_ignored", phase, 1);

        // Missing ticks while in MAIN.
        for (int i = 0; i < 60 && fault !== 1'b1; i++) @(posedge clk);
        #1;
`ifdef TICK_WATCHDOG_EN
        check("wdog_fault", fault, 1);
        check("wdog_code", fault_code, 6);
        pulse_clear();
`else
        check("no_wdog_fault", fault, 0);
        check("no_wdog_phase", phase, 1);
`endif

        // Reset asserted in the middle of a tick cycle.
        @(negedge clk);
        {MG, MR, CG, CR} = c_lc;
        displayM = seg(5);
        displayC = seg(5);
        tick = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("async_rst_phase", phase, 0);
        check("async_rst_cycles", cycle_count, 0);
        check("async_rst_digit", digitM, 0);
        @(posedge clk);
        #1;
        check("rst_discard", digitC, 0);
        tick = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_phase", phase, 0);

        $display("TB_RESULT checks=%0d failures=%0d", r_checks, r_failures);
        $finish;
    end

endmodule
`default_nettype wire
